i2c_slave_regs: RTL and testbench

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_slave_regs.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module      : i2c_slave_regs
// Description : I2C target exposing REG_DEPTH byte registers. The first written
//               byte sets an auto-incrementing pointer; later bytes are written or read.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  localparam int         c_PTR_W    = $clog2(REG_DEPTH);
  localparam logic [7:0] c_PTR_MASK = 8'(REG_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_scl_meta, r_scl_sync, r_scl_prev;
  logic       r_sda_meta, r_sda_sync, r_sda_prev;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_sda_out, w_sda_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_wr_en, w_wr_en_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       w_mem_we;
  logic [7:0] r_mem [REG_DEPTH];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0] w_byte, w_rd_byte;

  assign w_scl_rise = r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_sync & r_scl_prev;
  assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
  assign w_byte     = {r_shift[6:0], r_sda_sync};
  assign w_last_bit = (r_bit_cnt == 4'd7);
  assign w_rd_byte  = r_mem[r_ptr[c_PTR_W-1:0]];

  assign SDA_out     = r_sda_out;
  assign busy        = r_busy;
  assign reg_wr_en   = r_wr_en;
  assign reg_wr_addr = r_wr_addr;
  assign reg_wr_data = r_wr_data;

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_sda_nxt     = r_sda_out;
    w_busy_nxt    = r_busy;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_mem_we      = 1'b0;

    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_sda_nxt   = 1'b1;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_nxt     = 1'b1;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT: ;
        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (w_last_bit) begin
            w_bit_cnt_nxt = 4'd0;
            if (w_byte[7:1] == SLAVE_ADDR) begin
              w_rw_nxt    = w_byte[0];
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_ADDR_ACK;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
        // Count 0: first falling edge starts the ACK; count 1: ninth falling edge ends it.
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd0) begin
            w_sda_nxt     = 1'b0;
            w_bit_cnt_nxt = 4'd1;
          end else begin
            w_bit_cnt_nxt = 4'd0;
            if (r_state == S_ADDR_ACK && r_rw) begin
              w_state_nxt = S_RDATA;
              w_sda_nxt   = w_rd_byte[7];
              w_shift_nxt = {w_rd_byte[6:0], 1'b0};
            end else begin
              w_sda_nxt   = 1'b1;
              w_state_nxt = (r_state == S_ADDR_ACK) ? S_REG : S_WDATA;
            end
          end
        end
        S_REG: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (w_last_bit) begin
            w_ptr_nxt     = w_byte & c_PTR_MASK;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_REG_ACK;
          end
        end
        S_WDATA: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (w_last_bit) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_ptr;
            w_wr_data_nxt = w_byte;
            w_mem_we      = 1'b1;
            w_ptr_nxt     = (r_ptr + 8'd1) & c_PTR_MASK;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_WDATA_ACK;
          end
        end
        // Bit counter tracks master sampling edges; the falling edge after the 8th releases the line.
        S_RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_nxt     = 1'b1;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_RDATA_ACK;
            end else begin
              w_sda_nxt   = r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (!r_sda_sync) begin
              w_ptr_nxt     = (r_ptr + 8'd1) & c_PTR_MASK;
              w_bit_cnt_nxt = 4'd1;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_RDATA;
            w_sda_nxt     = w_rd_byte[7];
            w_shift_nxt   = {w_rd_byte[6:0], 1'b0};
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_rw       <= 1'b0;
      r_sda_out  <= 1'b1;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      for (int i = 0; i < REG_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_scl_meta <= scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= SDA_in;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_out  <= w_sda_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      if (w_mem_we) r_mem[r_ptr[c_PTR_W-1:0]] <= w_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module      : tb_i2c_slave_regs
// Description : Bit-banged I2C master with a transaction-level register model;
//               a write-strobe monitor pops expected writes from a queue.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_wire;
  logic       SDA_out, reg_wr_en, busy;
  logic [7:0] reg_wr_addr, reg_wr_data;

  // Open-drain bus: either side can pull the line low.
  assign sda_wire = m_sda & SDA_out;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .REG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .scl(m_scl), .SDA_in(sda_wire), .SDA_out(SDA_out),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          half    = 4;
  logic [7:0]  model_mem [16];
  int          model_ptr = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  wbuf [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    model_ptr = 0;
  endtask

  always @(negedge clk) begin
    if (!reset && reg_wr_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", reg_wr_addr, reg_wr_data);
      end else begin
        check("wr_strobe", {reg_wr_addr, reg_wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic start_cond();
    if (!m_scl) begin
      m_sda = 1'b1; cyc(half);
      m_scl = 1'b1; cyc(half);
    end
    m_sda = 1'b0; cyc(half);
    m_scl = 1'b0; cyc(1);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; cyc(half - 1);
    m_scl = 1'b1; cyc(half);
    m_sda = 1'b1; cyc(half);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    cyc(half - 1);
    m_scl = 1'b1; cyc(half);
    m_scl = 1'b0; cyc(1);
  endtask

  task automatic byte_write(input logic [7:0] b, input logic exp_ack, input string name);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; cyc(half - 1);
    m_scl = 1'b1; cyc(half / 2);
    check(name, SDA_out, exp_ack ? 1'b0 : 1'b1);
    cyc(half - half / 2);
    m_scl = 1'b0; cyc(1);
  endtask

  task automatic byte_read(input logic [7:0] exp, input logic nack, input string name);
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; cyc(half - 1);
      m_scl = 1'b1; cyc(half / 2);
      got[i] = SDA_out;
      cyc(half - half / 2);
      m_scl = 1'b0; cyc(1);
    end
    check(name, got, exp);
    m_sda = nack; cyc(half - 1);
    m_scl = 1'b1; cyc(half / 2);
    check({name, "_ackbit_released"}, SDA_out, 1'b1);
    cyc(half - half / 2);
    m_scl = 1'b0; cyc(1);
  endtask

  task automatic write_txn(input logic [7:0] reg_b);
    start_cond();
    byte_write(8'hA0, 1'b1, "w_addr_ack");
    check("w_busy", busy, 1'b1);
    byte_write(reg_b, 1'b1, "w_reg_ack");
    model_ptr = reg_b % 16;
    foreach (wbuf[i]) begin
      exp_q.push_back({8'(model_ptr), wbuf[i]});
      model_mem[model_ptr] = wbuf[i];
      model_ptr = (model_ptr + 1) % 16;
      byte_write(wbuf[i], 1'b1, "w_data_ack");
    end
    stop_cond();
    check("w_busy_after_stop", busy, 1'b0);
  endtask

  task automatic read_txn(input logic set_ptr, input logic [7:0] reg_b, input int n);
    logic last;
    start_cond();
    if (set_ptr) begin
      byte_write(8'hA0, 1'b1, "r_addr_w_ack");
      byte_write(reg_b, 1'b1, "r_reg_ack");
      model_ptr = reg_b % 16;
      start_cond();
    end
    byte_write(8'hA1, 1'b1, "r_addr_ack");
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      byte_read(model_mem[model_ptr], last, "r_data");
      if (!last) model_ptr = (model_ptr + 1) % 16;
    end
    stop_cond();
    check("r_sda_after_nack", SDA_out, 1'b1);
    check("r_busy_after_stop", busy, 1'b0);
  endtask

  task automatic mismatch_txn(input logic [7:0] addr_byte);
    start_cond();
    byte_write(addr_byte, 1'b0, "mm_addr_nack");
    check("mm_busy", busy, 1'b0);
    byte_write(8'h01, 1'b0, "mm_data_nack");
    stop_cond();
    check("mm_busy_after_stop", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] a;
    int         kind;
    model_reset();
    cyc(5);
    check("reset_outputs", {SDA_out, busy, reg_wr_en, reg_wr_addr, reg_wr_data}, {1'b1, 1'b0, 1'b0, 16'h0000});
    reset = 1'b0;
    cyc(5);

    // Basic write, then identical traffic at a slow bus clock.
    wbuf = '{8'hA5, 8'h5A};
    write_txn(8'h03);
    half = 100;
    wbuf = '{8'hC3, 8'h3C};
    write_txn(8'h03);
    read_txn(1'b1, 8'h03, 2);
    half = 4;
    read_txn(1'b1, 8'h03, 2);

    mismatch_txn(8'hA2);

    // Read across the top of the register file.
    wbuf = '{8'h77}; write_txn(8'h0F);
    wbuf = '{8'h11}; write_txn(8'h00);
    read_txn(1'b1, 8'h0F, 2);

    // Partial byte followed by STOP: nothing written, pointer stays at 2.
    start_cond();
    byte_write(8'hA0, 1'b1, "ab_addr_ack");
    byte_write(8'h02, 1'b1, "ab_reg_ack");
    model_ptr = 2;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    stop_cond();
    check("ab_busy_after_stop", busy, 1'b0);
    read_txn(1'b0, 8'h00, 1);

    // Reset while the slave is driving a 0 data bit.
    wbuf = '{8'h3C}; write_txn(8'h05);
    start_cond();
    byte_write(8'hA0, 1'b1, "rs_addr_w_ack");
    byte_write(8'h05, 1'b1, "rs_reg_ack");
    start_cond();
    byte_write(8'hA1, 1'b1, "rs_addr_r_ack");
    cyc(half - 1);
    check("rs_driving_zero", SDA_out, 1'b0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rs_release", {SDA_out, busy}, 2'b10);
    model_reset();
    stop_cond();
    wbuf = '{8'h96};
    write_txn(8'h09);
    read_txn(1'b1, 8'h09, 1);

    for (int t = 0; t < 25; t++) begin
      half = $urandom_range(4, 10);
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          wbuf.delete();
          for (int k = 0; k < $urandom_range(1, 4); k++) wbuf.push_back(8'($urandom_range(0, 255)));
          write_txn(8'($urandom_range(0, 255)));
        end
        1: read_txn(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
        2: read_txn(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h50) a = 7'h51;
          mismatch_txn({a, 1'($urandom_range(0, 1))});
        end
      endcase
    end

    cyc(20);
    check("wr_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
